// File: rtl/debug_controller_pkg.sv
// Shared widths, depths, command codes and FSM encodings for the UART debug controller.
package debug_pkg;

    localparam int NB_DATA        = 8;
    localparam int NB_WORD        = 32;
    localparam int NB_SIZE        = 16;
    localparam int NB_IM_ADDR     = 10;
    localparam int NB_RB_ADDR     = 5;
    localparam int RB_DEPTH       = 32;
    localparam int NB_DM_ADDR     = 7;
    localparam int DM_DEPTH       = 128;
    localparam int BYTES_PER_WORD = 4;

    localparam logic [NB_DATA-1:0] CMD_LOAD    = 8'h01;
    localparam logic [NB_DATA-1:0] CMD_RUN     = 8'h04;
    localparam logic [NB_DATA-1:0] CMD_STEP    = 8'h05;
    localparam logic [NB_DATA-1:0] CMD_SEND_BR = 8'h06;
    localparam logic [NB_DATA-1:0] CMD_SEND_PC = 8'h07;
    localparam logic [NB_DATA-1:0] CMD_SEND_DM = 8'h08;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_READY,
        ST_SIZE_LO,
        ST_SIZE_HI,
        ST_LOAD,
        ST_RUN,
        ST_STEP,
        ST_SEND_BR,
        ST_SEND_PC,
        ST_SEND_DM
    } state_e;

    // Sub-phases of one dumped word: drive address, capture read data, wait for serializer.
    typedef enum logic [1:0] {
        PH_ADDR,
        PH_CAPTURE,
        PH_WAIT
    } phase_e;

endpackage

// File: rtl/debug_controller_if.sv
// UART, instruction/data memory, register bank and control signals seen by the debug controller.
interface debug_controller_if;
    import debug_pkg::*;

    logic                  i_rx_done;
    logic [NB_DATA-1:0]    i_rx_data;
    logic                  i_tx_done;
    logic                  i_hlt;
    logic [NB_WORD-1:0]    i_pc_value;
    logic [NB_WORD-1:0]    i_rb_data;
    logic [NB_WORD-1:0]    i_dm_data;
    logic [NB_DATA-1:0]    o_im_data;
    logic [NB_IM_ADDR-1:0] o_im_addr;
    logic                  o_im_write_enable;
    logic [NB_RB_ADDR-1:0] o_rb_addr;
    logic                  o_rb_read_enable;
    logic [NB_DM_ADDR-1:0] o_dm_addr;
    logic                  o_dm_read_enable;
    logic [NB_DATA-1:0]    o_tx_data;
    logic                  o_tx_start;
    logic                  o_cu_enable;
    logic                  o_halted;
    logic                  o_busy;

    modport master (
        input  i_rx_done, i_rx_data, i_tx_done, i_hlt, i_pc_value, i_rb_data, i_dm_data,
        output o_im_data, o_im_addr, o_im_write_enable, o_rb_addr, o_rb_read_enable,
               o_dm_addr, o_dm_read_enable, o_tx_data, o_tx_start, o_cu_enable,
               o_halted, o_busy
    );

    modport slave (
        output i_rx_done, i_rx_data, i_tx_done, i_hlt, i_pc_value, i_rb_data, i_dm_data,
        input  o_im_data, o_im_addr, o_im_write_enable, o_rb_addr, o_rb_read_enable,
               o_dm_addr, o_dm_read_enable, o_tx_data, o_tx_start, o_cu_enable,
               o_halted, o_busy
    );

endinterface

// File: rtl/debug_controller_word_serializer.sv
// Sends one NB_WORD word as BYTES_PER_WORD bytes, LSB first, one byte in flight at a time.
module word_serializer
    import debug_pkg::*;
(
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_load,
    input  logic [NB_WORD-1:0] i_word,
    input  logic               i_tx_done,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_start,
    output logic               o_done
);

    localparam int NB_CNT = $clog2(BYTES_PER_WORD);

    logic [NB_WORD-1:0] shift_q, shift_d;
    logic [NB_CNT-1:0]  cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               start_q, start_d;
    logic               done_q, done_d;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            shift_q <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            start_q <= start_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        start_d = 1'b0;
        done_d  = 1'b0;
        if (i_load) begin
            shift_d = i_word;
            cnt_d   = '0;
            busy_d  = 1'b1;
            start_d = 1'b1;
        end else if (busy_q && i_tx_done) begin
            // The byte in flight is finished: either close the word or launch the next byte.
            if (cnt_q == NB_CNT'(BYTES_PER_WORD - 1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end else begin
                shift_d = shift_q >> NB_DATA;
                cnt_d   = cnt_q + 1'b1;
                start_d = 1'b1;
            end
        end
    end

    assign o_tx_data  = shift_q[NB_DATA-1:0];
    assign o_tx_start = start_q;
    assign o_done     = done_q;

endmodule

// File: rtl/debug_controller.sv
// UART debug controller: program load, run/step control and register/memory/PC dumps.
module debug_controller
    import debug_pkg::*;
(
    input  logic               i_clock,
    input  logic               i_reset,
    debug_controller_if.master bus
);

    state_e                state_q, state_d;
    state_e                ret_q, ret_d;
    phase_e                phase_q, phase_d;
    logic [NB_SIZE-1:0]    size_q, size_d;
    logic [NB_SIZE-1:0]    cnt_q, cnt_d;
    logic [NB_DM_ADDR-1:0] addr_q, addr_d;
    logic                  halted_q, halted_d;

    logic                  ser_load;
    logic [NB_WORD-1:0]    ser_word;
    logic                  ser_done;
    logic [NB_DATA-1:0]    ser_tx_data;
    logic                  ser_tx_start;

    logic                  im_we;
    logic [NB_DATA-1:0]    im_data;
    logic [NB_IM_ADDR-1:0] im_addr;
    logic                  rb_re;
    logic                  dm_re;
    logic                  last_word;

    word_serializer u_serializer (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_load     (ser_load),
        .i_word     (ser_word),
        .i_tx_done  (bus.i_tx_done),
        .o_tx_data  (ser_tx_data),
        .o_tx_start (ser_tx_start),
        .o_done     (ser_done)
    );

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q  <= ST_IDLE;
            ret_q    <= ST_IDLE;
            phase_q  <= PH_ADDR;
            size_q   <= '0;
            cnt_q    <= '0;
            addr_q   <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ret_q    <= ret_d;
            phase_q  <= phase_d;
            size_q   <= size_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            halted_q <= halted_d;
        end
    end

    assign last_word = (state_q == ST_SEND_BR) ? (addr_q == NB_DM_ADDR'(RB_DEPTH - 1))
                                               : (addr_q == NB_DM_ADDR'(DM_DEPTH - 1));

    always_comb begin
        state_d  = state_q;
        ret_d    = ret_q;
        phase_d  = phase_q;
        size_d   = size_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        halted_d = halted_q;
        ser_load = 1'b0;
        ser_word = '0;
        im_we    = 1'b0;
        im_data  = '0;
        im_addr  = '0;
        rb_re    = 1'b0;
        dm_re    = 1'b0;

        case (state_q)
            ST_IDLE, ST_READY: begin
                if (bus.i_rx_done) begin
                    case (bus.i_rx_data)
                        CMD_LOAD: state_d = ST_SIZE_LO;
                        CMD_RUN: begin
                            if (state_q == ST_READY && !halted_q) state_d = ST_RUN;
                        end
                        CMD_STEP: begin
                            if (state_q == ST_READY && !halted_q) state_d = ST_STEP;
                        end
                        CMD_SEND_BR, CMD_SEND_DM, CMD_SEND_PC: begin
                            ret_d   = state_q;
                            phase_d = PH_ADDR;
                            addr_d  = '0;
                            state_d = (bus.i_rx_data == CMD_SEND_BR) ? ST_SEND_BR :
                                      (bus.i_rx_data == CMD_SEND_DM) ? ST_SEND_DM : ST_SEND_PC;
                        end
                        default: ;
                    endcase
                end
            end
            ST_SIZE_LO: begin
                if (bus.i_rx_done) begin
                    size_d[NB_DATA-1:0] = bus.i_rx_data;
                    state_d             = ST_SIZE_HI;
                end
            end
            ST_SIZE_HI: begin
                if (bus.i_rx_done) begin
                    size_d[NB_SIZE-1:NB_DATA] = bus.i_rx_data;
                    cnt_d                     = '0;
                    state_d = ({bus.i_rx_data, size_q[NB_DATA-1:0]} == '0) ? ST_READY : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (bus.i_rx_done) begin
                    im_we   = 1'b1;
                    im_data = bus.i_rx_data;
                    im_addr = cnt_q[NB_IM_ADDR-1:0];
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == size_q - 1'b1) begin
                        state_d  = ST_READY;
                        halted_d = 1'b0;
                    end
                end
            end
            ST_RUN: begin
                if (bus.i_hlt) begin
                    halted_d = 1'b1;
                    state_d  = ST_READY;
                end
            end
            ST_STEP: begin
                if (bus.i_hlt) halted_d = 1'b1;
                ret_d   = ST_READY;
                phase_d = PH_ADDR;
                state_d = ST_SEND_PC;
            end
            ST_SEND_PC: begin
                // PC is sampled on the first cycle here, after any step has updated it.
                if (phase_q == PH_ADDR) begin
                    ser_load = 1'b1;
                    ser_word = bus.i_pc_value;
                    phase_d  = PH_WAIT;
                end else if (ser_done) begin
                    state_d = ret_q;
                end
            end
            ST_SEND_BR, ST_SEND_DM: begin
                case (phase_q)
                    PH_ADDR: begin
                        rb_re   = (state_q == ST_SEND_BR);
                        dm_re   = (state_q == ST_SEND_DM);
                        phase_d = PH_CAPTURE;
                    end
                    PH_CAPTURE: begin
                        ser_load = 1'b1;
                        ser_word = (state_q == ST_SEND_BR) ? bus.i_rb_data : bus.i_dm_data;
                        phase_d  = PH_WAIT;
                    end
                    PH_WAIT: begin
                        if (ser_done) begin
                            if (last_word) begin
                                state_d = ret_q;
                            end else begin
                                addr_d  = addr_q + 1'b1;
                                phase_d = PH_ADDR;
                            end
                        end
                    end
                    default: phase_d = PH_ADDR;
                endcase
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.o_im_data         = im_data;
    assign bus.o_im_addr         = im_addr;
    assign bus.o_im_write_enable = im_we;
    assign bus.o_rb_addr         = addr_q[NB_RB_ADDR-1:0];
    assign bus.o_rb_read_enable  = rb_re;
    assign bus.o_dm_addr         = addr_q;
    assign bus.o_dm_read_enable  = dm_re;
    assign bus.o_tx_data         = ser_tx_data;
    assign bus.o_tx_start        = ser_tx_start;
    assign bus.o_cu_enable       = (state_q == ST_RUN) || (state_q == ST_STEP);
    assign bus.o_halted          = halted_q;
    assign bus.o_busy            = (state_q != ST_IDLE) && (state_q != ST_READY);

endmodule

// File: tb/tb_debug_controller.sv
// Scoreboard bench for debug_controller: expected tx bytes / im writes are queued at stimulus time.
module tb_debug_controller;
    import debug_pkg::*;

    logic clk;
    logic rst_n;

    debug_controller_if dbg ();

    debug_controller dut (
        .i_clock (clk),
        .i_reset (rst_n),
        .bus     (dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [7:0]  obs_tx[$];
    logic [7:0]  exp_tx[$];
    logic [17:0] obs_im[$];
    logic [17:0] exp_im[$];
    logic [4:0]  obs_rb[$];
    int          rd_tx = 0;
    int          rd_im = 0;
    int          rd_rb = 0;
    int          cu_cnt = 0;
    int          tx_wait;

    function automatic logic [31:0] dm_word(input logic [6:0] a);
        dm_word = {8'hD0, 1'b0, a, 8'hA5, 1'b0, ~a};
    endfunction

    function automatic logic [44:0] all_outs();
        all_outs = {dbg.o_im_data, dbg.o_im_addr, dbg.o_im_write_enable, dbg.o_rb_addr,
                    dbg.o_rb_read_enable, dbg.o_dm_addr, dbg.o_dm_read_enable, dbg.o_tx_data,
                    dbg.o_tx_start, dbg.o_cu_enable, dbg.o_halted, dbg.o_busy};
    endfunction

    // UART transmitter: finishes each byte three cycles after its start pulse.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_wait       <= 0;
            dbg.i_tx_done <= 1'b0;
        end else begin
            dbg.i_tx_done <= 1'b0;
            if (dbg.o_tx_start) tx_wait <= 3;
            else if (tx_wait == 1) begin
                dbg.i_tx_done <= 1'b1;
                tx_wait       <= 0;
            end else if (tx_wait != 0) tx_wait <= tx_wait - 1;
        end
    end

    // Register bank and data memory with one-cycle read latency.
    always @(posedge clk) begin
        if (dbg.o_rb_read_enable) dbg.i_rb_data <= {4{3'b000, dbg.o_rb_addr}};
        if (dbg.o_dm_read_enable) dbg.i_dm_data <= dm_word(dbg.o_dm_addr);
    end

    always @(negedge clk) begin
        if (dbg.o_tx_start) obs_tx.push_back(dbg.o_tx_data);
        if (dbg.o_im_write_enable) obs_im.push_back({dbg.o_im_addr, dbg.o_im_data});
        if (dbg.o_rb_read_enable) obs_rb.push_back(dbg.o_rb_addr);
        if (dbg.o_cu_enable) cu_cnt = cu_cnt + 1;
    end

    task automatic send_rx(input logic [7:0] b);
        @(posedge clk); #1;
        dbg.i_rx_data = b;
        dbg.i_rx_done = 1'b1;
        @(posedge clk); #1;
        dbg.i_rx_done = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit timed_out);
        int n = 0;
        while (dbg.o_busy !== 1'b0 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        timed_out = (dbg.o_busy !== 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (all_outs() !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h required 0", all_outs());
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (dbg.o_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b required 0", dbg.o_busy);
        end
    endtask

    task automatic test_load();
        logic [7:0] prog [4];
        logic [17:0] e;
        prog = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        send_rx(CMD_LOAD);
        send_rx(8'h04);
        send_rx(8'h00);
        for (int i = 0; i < 4; i++) begin
            exp_im.push_back({10'(i), prog[i]});
            send_rx(prog[i]);
        end
        while (exp_im.size() > 0) begin
            e = exp_im.pop_front();
            checks++;
            if (rd_im >= obs_im.size()) begin
                errors++;
                $display("FAIL load_write: missing, required addr=%0d data=%h", e[17:8], e[7:0]);
            end else begin
                if (obs_im[rd_im] !== e) begin
                    errors++;
                    $display("FAIL load_write: got addr=%0d data=%h required addr=%0d data=%h",
                             obs_im[rd_im][17:8], obs_im[rd_im][7:0], e[17:8], e[7:0]);
                end
                rd_im++;
            end
        end
        checks++;
        if (dbg.o_busy !== 1'b0) begin
            errors++;
            $display("FAIL load_ready: busy=%b required 0", dbg.o_busy);
        end
    endtask

    task automatic test_size_zero();
        send_rx(CMD_LOAD);
        send_rx(8'h00);
        send_rx(8'h00);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (obs_im.size() !== rd_im) begin
            errors++;
            $display("FAIL size_zero_writes: got %0d writes required 0", obs_im.size() - rd_im);
        end
        checks++;
        if (dbg.o_busy !== 1'b0) begin
            errors++;
            $display("FAIL size_zero_ready: busy=%b required 0", dbg.o_busy);
        end
    endtask

    task automatic test_step();
        int  cu0;
        bit  to;
        logic [7:0] e;
        dbg.i_pc_value = 32'h0000_0004;
        exp_tx.push_back(8'h04); exp_tx.push_back(8'h00);
        exp_tx.push_back(8'h00); exp_tx.push_back(8'h00);
        cu0 = cu_cnt;
        send_rx(CMD_STEP);
        wait_idle(500, to);
        checks++;
        if (to !== 1'b0) begin
            errors++;
            $display("FAIL step_done: busy=%b required 0", dbg.o_busy);
        end
        checks++;
        if (cu_cnt - cu0 !== 1) begin
            errors++;
            $display("FAIL step_cu_cycles: got %0d required 1", cu_cnt - cu0);
        end
        while (exp_tx.size() > 0) begin
            e = exp_tx.pop_front();
            checks++;
            if (rd_tx >= obs_tx.size()) begin
                errors++;
                $display("FAIL step_tx: missing byte, required %h", e);
            end else begin
                if (obs_tx[rd_tx] !== e) begin
                    errors++;
                    $display("FAIL step_tx: byte %0d got %h required %h", rd_tx, obs_tx[rd_tx], e);
                end
                rd_tx++;
            end
        end
        checks++;
        if (obs_tx.size() !== rd_tx) begin
            errors++;
            $display("FAIL step_tx_count: got %0d extra bytes required 0", obs_tx.size() - rd_tx);
        end
    endtask

    task automatic test_reg_dump();
        bit to;
        logic [7:0] e;
        for (int n = 0; n < RB_DEPTH; n++)
            for (int b = 0; b < 4; b++) exp_tx.push_back(8'(n));
        send_rx(CMD_SEND_BR);
        repeat (40) @(posedge clk);
        // A command arriving mid-dump must be dropped.
        send_rx(CMD_SEND_PC);
        wait_idle(5000, to);
        checks++;
        if (to !== 1'b0) begin
            errors++;
            $display("FAIL reg_dump_done: busy=%b required 0", dbg.o_busy);
        end
        for (int n = 0; n < RB_DEPTH; n++) begin
            checks++;
            if (rd_rb >= obs_rb.size()) begin
                errors++;
                $display("FAIL reg_dump_addr: missing read, required %0d", n);
            end else begin
                if (obs_rb[rd_rb] !== 5'(n)) begin
                    errors++;
                    $display("FAIL reg_dump_addr: got %0d required %0d", obs_rb[rd_rb], n);
                end
                rd_rb++;
            end
        end
        while (exp_tx.size() > 0) begin
            e = exp_tx.pop_front();
            checks++;
            if (rd_tx >= obs_tx.size()) begin
                errors++;
                $display("FAIL reg_dump_tx: missing byte, required %h", e);
            end else begin
                if (obs_tx[rd_tx] !== e) begin
                    errors++;
                    $display("FAIL reg_dump_tx: byte %0d got %h required %h", rd_tx, obs_tx[rd_tx], e);
                end
                rd_tx++;
            end
        end
        checks++;
        if (obs_tx.size() !== rd_tx) begin
            errors++;
            $display("FAIL reg_dump_count: got %0d extra bytes required 0", obs_tx.size() - rd_tx);
        end
    endtask

    task automatic test_reset_mid_dump();
        int base;
        int n = 0;
        int cu0;
        bit to;
        logic [31:0] w;
        logic [7:0] e;
        base = obs_tx.size();
        for (int k = 0; k < 10; k++) begin
            w = dm_word(7'(k / 4));
            exp_tx.push_back(w[8*(k%4) +: 8]);
        end
        send_rx(CMD_SEND_DM);
        while (obs_tx.size() < base + 10 && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (all_outs() !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got %h required 0", all_outs());
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (obs_tx.size() !== base + 10) begin
            errors++;
            $display("FAIL mid_reset_bytes: got %0d bytes required 10", obs_tx.size() - base);
        end
        while (exp_tx.size() > 0) begin
            e = exp_tx.pop_front();
            checks++;
            if (rd_tx >= obs_tx.size()) begin
                errors++;
                $display("FAIL dm_dump_tx: missing byte, required %h", e);
            end else begin
                if (obs_tx[rd_tx] !== e) begin
                    errors++;
                    $display("FAIL dm_dump_tx: byte %0d got %h required %h", rd_tx, obs_tx[rd_tx], e);
                end
                rd_tx++;
            end
        end
        rd_tx = obs_tx.size();

        dbg.i_pc_value = 32'h1234_5678;
        exp_tx.push_back(8'h78); exp_tx.push_back(8'h56);
        exp_tx.push_back(8'h34); exp_tx.push_back(8'h12);
        send_rx(CMD_SEND_PC);
        wait_idle(500, to);
        checks++;
        if (to !== 1'b0) begin
            errors++;
            $display("FAIL pc_after_reset_done: busy=%b required 0", dbg.o_busy);
        end
        while (exp_tx.size() > 0) begin
            e = exp_tx.pop_front();
            checks++;
            if (rd_tx >= obs_tx.size()) begin
                errors++;
                $display("FAIL pc_after_reset_tx: missing byte, required %h", e);
            end else begin
                if (obs_tx[rd_tx] !== e) begin
                    errors++;
                    $display("FAIL pc_after_reset_tx: got %h required %h", obs_tx[rd_tx], e);
                end
                rd_tx++;
            end
        end
        // Back in IDLE after the dump, so RUN must be ignored.
        cu0 = cu_cnt;
        send_rx(CMD_RUN);
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (cu_cnt !== cu0 || dbg.o_busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_run_ignored: cu_cycles=%0d busy=%b required 0 0", cu_cnt - cu0, dbg.o_busy);
        end
    endtask

    task automatic test_run_halt();
        int cu0;
        send_rx(CMD_LOAD);
        send_rx(8'h00);
        send_rx(8'h00);
        send_rx(CMD_RUN);
        cu0 = cu_cnt;
        repeat (20) @(posedge clk);
        #1;
        dbg.i_hlt = 1'b1;
        checks++;
        if (dbg.o_cu_enable !== 1'b1) begin
            errors++;
            $display("FAIL run_cu_at_20: got %b required 1", dbg.o_cu_enable);
        end
        @(posedge clk); #1;
        dbg.i_hlt = 1'b0;
        checks++;
        if (dbg.o_cu_enable !== 1'b0 || dbg.o_halted !== 1'b1 || dbg.o_busy !== 1'b0) begin
            errors++;
            $display("FAIL run_halt_state: cu=%b halted=%b busy=%b required 0 1 0",
                     dbg.o_cu_enable, dbg.o_halted, dbg.o_busy);
        end
        checks++;
        if (cu_cnt - cu0 !== 21) begin
            errors++;
            $display("FAIL run_cu_cycles: got %0d required 21", cu_cnt - cu0);
        end
        cu0 = cu_cnt;
        send_rx(CMD_RUN);
        send_rx(CMD_STEP);
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (cu_cnt !== cu0) begin
            errors++;
            $display("FAIL halted_run_ignored: got %0d cu cycles required 0", cu_cnt - cu0);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [6];
        logic [17:0] e;
        bytes = '{CMD_LOAD, 8'h03, 8'h00, 8'h11, 8'h22, 8'h33};
        exp_im.push_back({10'd0, 8'h11});
        exp_im.push_back({10'd1, 8'h22});
        exp_im.push_back({10'd2, 8'h33});
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) begin
            dbg.i_rx_data = bytes[i];
            dbg.i_rx_done = 1'b1;
            @(posedge clk); #1;
        end
        dbg.i_rx_done = 1'b0;
        while (exp_im.size() > 0) begin
            e = exp_im.pop_front();
            checks++;
            if (rd_im >= obs_im.size()) begin
                errors++;
                $display("FAIL b2b_write: missing, required addr=%0d data=%h", e[17:8], e[7:0]);
            end else begin
                if (obs_im[rd_im] !== e) begin
                    errors++;
                    $display("FAIL b2b_write: got %h required %h", obs_im[rd_im], e);
                end
                rd_im++;
            end
        end
        checks++;
        if (dbg.o_halted !== 1'b0 || dbg.o_busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_ready: halted=%b busy=%b required 0 0", dbg.o_halted, dbg.o_busy);
        end
    endtask

    initial begin
        dbg.i_rx_done  = 1'b0;
        dbg.i_rx_data  = '0;
        dbg.i_hlt      = 1'b0;
        dbg.i_pc_value = '0;
        test_reset();
        test_load();
        test_size_zero();
        test_step();
        test_reg_dump();
        test_reset_mid_dump();
        test_run_halt();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/debug_controller.md
Name: debug_controller

Overview:
UART-driven debug controller between the uart rx/tx pair and the pipelined MIPS datapath. Loads a program byte stream into instruction memory. Runs the datapath continuously or one clock at a time. Dumps register bank, data memory and PC back over UART as little-endian 32-bit words. Parametrised successor of the first-generation debug unit: full load/run/step/dump command set, word-wide memory read-back, and a byte serializer sub-module.

Parameters:
NB_DATA, 8, UART byte width
NB_WORD, 32, datapath word width (PC, register, data-memory word)
NB_SIZE, 16, width of program-size field in bytes
NB_IM_ADDR, 10, instruction-memory byte address width
NB_RB_ADDR, 5, register-bank address width
RB_DEPTH, 32, registers dumped
NB_DM_ADDR, 7, data-memory word address width
DM_DEPTH, 128, data-memory words dumped
BYTES_PER_WORD, 4, bytes per serialized word

Ports:
i_clock  in  1  system clock
i_reset  in  1  asynchronous, active-low reset (0 = reset)
i_rx_done  in  1  one-cycle pulse: i_rx_data valid
i_rx_data  in  NB_DATA  received byte
i_tx_done  in  1  one-cycle pulse: tx finished current byte
i_hlt  in  1  datapath executed HALT
i_pc_value  in  NB_WORD  current PC
i_rb_data  in  NB_WORD  register-bank read data, valid 1 cycle after address
i_dm_data  in  NB_WORD  data-memory read data, valid 1 cycle after address
o_im_data  out  NB_DATA  byte to write into instruction memory
o_im_addr  out  NB_IM_ADDR  instruction-memory byte address
o_im_write_enable  out  1  one-cycle write strobe
o_rb_addr  out  NB_RB_ADDR  register-bank read address
o_rb_read_enable  out  1  register-bank debug read enable
o_dm_addr  out  NB_DM_ADDR  data-memory read address
o_dm_read_enable  out  1  data-memory debug read enable
o_tx_data  out  NB_DATA  byte to transmit
o_tx_start  out  1  one-cycle pulse: start transmission
o_cu_enable  out  1  datapath clock-enable
o_halted  out  1  sticky: program reached HALT
o_busy  out  1  high in every state except IDLE and READY

Behaviour:
- Reset: all outputs 0, state IDLE, all counters 0. Reset mid-operation aborts immediately; no partial byte is completed.
- Commands, decoded only on i_rx_done in IDLE or READY:
  - 0x01 LOAD → SIZE_LO.
  - 0x04 RUN → RUN (READY only).
  - 0x05 STEP → STEP (READY only).
  - 0x06 → SEND_BR.
  - 0x07 → SEND_PC.
  - 0x08 → SEND_DM.
  - Other bytes ignored, state unchanged.
- SIZE_LO/SIZE_HI: next two rx bytes form size, LSB first.
  - Size 0 → READY directly.
  - Otherwise → LOAD, byte counter cleared.
- LOAD: on each i_rx_done, in the same cycle: o_im_write_enable=1, o_im_data=i_rx_data, o_im_addr=counter[NB_IM_ADDR-1:0]. Counter then increments; the address wraps modulo 2^NB_IM_ADDR.
  - After the size-th byte → READY; o_halted cleared.
- RUN: o_cu_enable=1 every cycle. On i_hlt=1: o_cu_enable=0 from the next cycle, o_halted=1 → READY.
- STEP: o_cu_enable=1 for exactly one cycle, then PC auto-sent (SEND_PC path) → READY. If i_hlt is seen during the step cycle, set o_halted.
- RUN/STEP while o_halted=1 are ignored.
- Return state: all dumps return to the state they were issued from (IDLE or READY).
- SEND_BR / SEND_DM, per word:
  - Drive the address with read_enable=1 for one cycle.
  - Capture read data on the next cycle.
  - Serialize 4 bytes, then increment the address.
  - Totals: RB_DEPTH and DM_DEPTH words, addresses 0..DEPTH-1.
- SEND_PC: i_pc_value captured on entry, 4 bytes sent.
- Serialization: o_tx_start pulses one cycle per byte, LSB first. The next byte starts only after i_tx_done. The serializer issues at most one byte in flight.
- rx bytes arriving while o_busy=1 and not in SIZE/LOAD are dropped.
- Simultaneous i_rx_done and i_tx_done: both handled in the same cycle; neither is lost.

Decomposition:
- Package debug_pkg: state encodings and command codes (CMD_LOAD=0x01, CMD_RUN=0x04, CMD_STEP=0x05, CMD_SEND_BR=0x06, CMD_SEND_PC=0x07, CMD_SEND_DM=0x08).
- Sub-module word_serializer:
  - Inputs: i_load, i_word[NB_WORD].
  - Outputs: o_tx_data, o_tx_start, o_done pulse after the 4th i_tx_done.
  - Counts BYTES_PER_WORD bytes and shifts right by NB_DATA per byte.

Test Plan:
- Load: rx 0x01,0x04,0x00,0xAA,0xBB,0xCC,0xDD → four im writes, addresses 0..3, data AA..DD → READY, o_busy=0.
- Size zero: rx 0x01,0x00,0x00 → READY, no im write.
- Step: READY, rx 0x05, i_pc_value=0x00000004 → o_cu_enable high exactly 1 cycle; tx 04,00,00,00.
- Run/halt: rx 0x04, assert i_hlt at cycle 20 → o_cu_enable low at cycle 21, o_halted=1; a later 0x04 produces no o_cu_enable.
- Register dump: rx 0x06, register n = n*0x01010101 → 128 tx bytes, reg 3 as 03,03,03,03; o_rb_addr 0..31 in order.
- Reset mid-dump: rx 0x08, assert i_reset low after 10 bytes → all outputs 0, state IDLE; a later rx 0x07 sends PC normally.
